// File: rtl/serializador_16b.sv
// 16-bit parallel-to-serial converter.
// A word captured on an accepted load is shifted out one bit per cycle for 16 cycles,
// followed by a single-cycle done pulse, then the block returns to idle.
module serializador_16b #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic        load,
    output logic        ready,
    output logic        sout,
    output logic        sout_valid,
    output logic        done
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] shreg_q, shreg_d;
    logic [3:0]  cnt_q, cnt_d;

    // State, shift register and bit counter; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shreg_q <= 16'h0000;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and Moore outputs decoded from the current state.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        ready      = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        done       = 1'b0;

        case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (load) begin
                    shreg_d = a;
                    cnt_d   = 4'd0;
                    state_d = StShift;
                end
            end

            StShift: begin
                sout_valid = 1'b1;
                sout       = MSB_FIRST ? shreg_q[15] : shreg_q[0];
                // Shift toward the output end; the vacated end fills with zero.
                if (MSB_FIRST) begin
                    shreg_d = {shreg_q[14:0], 1'b0};
                end else begin
                    shreg_d = {1'b0, shreg_q[15:1]};
                end
                // Counter wraps 15 -> 0 naturally as the last bit leaves.
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = StDone;
                end
            end

            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end

            default: begin
                // Unused encoding: recover to idle on the next edge.
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_serializador_16b.sv
// Bench for serializador_16b: both shift orders run side by side on shared inputs.
// A transaction-level model queues the expected bit stream per accepted word and tracks
// how many cycles the transfer still occupies; a monitor compares every cycle.
module tb_serializador_16b;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic        load;

    logic ready_m, sout_m, sout_valid_m, done_m;
    logic ready_l, sout_l, sout_valid_l, done_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: cycles remaining in the current transfer (16 bits + 1 done cycle).
    int busy = 0;
    bit q_msb[$];
    bit q_lsb[$];

    serializador_16b #(.MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .load       (load),
        .ready      (ready_m),
        .sout       (sout_m),
        .sout_valid (sout_valid_m),
        .done       (done_m)
    );

    serializador_16b #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .load       (load),
        .ready      (ready_l),
        .sout       (sout_l),
        .sout_valid (sout_valid_l),
        .done       (done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: a word is accepted only when no transfer is in progress.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy = 0;
            q_msb.delete();
            q_lsb.delete();
        end else if (busy == 0) begin
            if (load) begin
                for (int i = 0; i < 16; i++) begin
                    q_msb.push_back(a[15 - i]);
                    q_lsb.push_back(a[i]);
                end
                busy = 17;
            end
        end else begin
            busy = busy - 1;
        end
    end

    // Monitor: cycle-level handshake checks plus scoreboard pops on each valid bit.
    always @(negedge clk) begin
        logic exp_ready, exp_valid, exp_done;
        bit   exp_bit;
        exp_ready = (busy == 0);
        exp_valid = (busy >= 2);
        exp_done  = (busy == 1);

        check("ready_msb", ready_m, exp_ready);
        check("valid_msb", sout_valid_m, exp_valid);
        check("done_msb", done_m, exp_done);
        if (sout_valid_m) begin
            if (q_msb.size() == 0) begin
                check("sout_msb_underflow", 1'b1, 1'b0);
            end else begin
                exp_bit = q_msb.pop_front();
                check("sout_msb", sout_m, exp_bit);
            end
        end else begin
            check("sout_msb_idle", sout_m, 1'b0);
        end

        check("ready_lsb", ready_l, exp_ready);
        check("valid_lsb", sout_valid_l, exp_valid);
        check("done_lsb", done_l, exp_done);
        if (sout_valid_l) begin
            if (q_lsb.size() == 0) begin
                check("sout_lsb_underflow", 1'b1, 1'b0);
            end else begin
                exp_bit = q_lsb.pop_front();
                check("sout_lsb", sout_l, exp_bit);
            end
        end else begin
            check("sout_lsb_idle", sout_l, 1'b0);
        end
    end

    // Advance to just after the next rising edge; inputs change only here.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [15:0] word);
        a    = word;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_ready_msb", ready_m, 1'b1);
        check("rst_sout_msb", sout_m, 1'b0);
        check("rst_valid_msb", sout_valid_m, 1'b0);
        check("rst_done_msb", done_m, 1'b0);
        check("rst_ready_lsb", ready_l, 1'b1);
        check("rst_sout_lsb", sout_l, 1'b0);
        check("rst_valid_lsb", sout_valid_l, 1'b0);
        check("rst_done_lsb", done_l, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        a     = 16'h0000;
        #1;
        check_reset_outputs();
        step(2);
        rst_n = 1'b1;
        step(5);

        // Single words, both orders observed at once.
        send(16'hA5C3);
        step(18);
        send(16'h0001);
        step(18);

        // Loads during shift and during done must be ignored.
        send(16'hFFFF);
        step(4);
        send(16'h0000);
        a = 16'h1357;
        step(11);
        send(16'h0000);
        step(4);

        // Reset in the middle of a transfer, asserted between clock edges.
        send(16'h1234);
        step(7);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        step(2);
        rst_n = 1'b1;
        step(1);
        send(16'h8001);
        step(18);

        // Load held high: back-to-back transfers every 18 cycles.
        a    = 16'hF0F0;
        load = 1'b1;
        step(56);
        load = 1'b0;
        step(18);

        // Random loads and data, including data churn mid-transfer.
        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(0, 3) == 0);
            a    = 16'($urandom);
            step(1);
        end
        load = 1'b0;
        step(20);

        n_checks++;
        if (q_msb.size() != 0 || q_lsb.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_bits: got %0d/%0d queued, expected 0/0",
                     q_msb.size(), q_lsb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serializador_16b.md
SERIALIZADOR_16B -- requirements
Module: serializador_16b

Interface
REQ-001 Parameter MSB_FIRST, default 1, SHALL select the shift order: 1 = bit 15 first, 0 = bit 0 first.
REQ-002 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 A  input  16  SHALL be the parallel data word to transmit; sampled only on an accepted load.
REQ-005 Load  input  1  SHALL be the load request; accepted only when Ready=1.
REQ-006 Ready  output  1  SHALL be high when the block can accept a new word.
REQ-007 Sout  output  1  SHALL be the serial data bit.
REQ-008 Sout_valid  output  1  SHALL be high during each cycle that Sout carries a valid data bit.
REQ-009 Done  output  1  SHALL be a one-cycle pulse marking completion of a 16-bit transfer.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-011 IDLE outputs SHALL be: Ready=1, Sout_valid=0, Sout=0, Done=0.
REQ-012 IDLE transition: on a rising edge with Load=1, A SHALL be captured into a 16-bit shift register, the 4-bit bit counter cleared to 0, and the FSM SHALL enter SHIFT.
REQ-013 Load=0 in IDLE SHALL keep the FSM in IDLE with all internal state held.
REQ-014 SHIFT outputs SHALL be: Ready=0, Sout_valid=1, Done=0.
REQ-015 In SHIFT, Sout SHALL present the current bit: shift-register bit 15 when MSB_FIRST=1, bit 0 when MSB_FIRST=0.
REQ-016 On each SHIFT edge, the register SHALL shift one position toward the output end and the counter SHALL increment.
REQ-017 The vacated end of the shift register SHALL fill with 0.
REQ-018 When the counter is 15 at a SHIFT edge, the FSM SHALL enter DONE and the counter SHALL wrap to 0.
REQ-019 Latency: with Load accepted at edge k, the 16 data bits SHALL appear on Sout in cycles k+1 through k+16, one bit per cycle, with no gaps.
REQ-020 DONE outputs SHALL be: Done=1, Ready=0, Sout_valid=0, Sout=0; the FSM SHALL return to IDLE unconditionally on the next edge.
REQ-021 Done SHALL be high in cycle k+17 only, and Ready SHALL be 1 again from cycle k+18.
REQ-022 Load asserted while Ready=0 (SHIFT or DONE) SHALL be ignored; the transfer in progress and the captured word SHALL be unaffected.
REQ-023 Changes on A after capture SHALL NOT affect the word being transmitted.
REQ-024 Load held high continuously SHALL start a new transfer every 18 cycles, each transfer capturing A at the edge where Ready=1.
REQ-025 Unreachable FSM encodings SHALL return to IDLE on the next edge.

Reset
REQ-026 Reset=0 SHALL immediately, independent of Clk, force: FSM=IDLE, shift register=0x0000, counter=0, Ready=1, Sout=0, Sout_valid=0, Done=0.
REQ-027 Reset asserted mid-transfer SHALL abandon the transfer; no Done pulse SHALL follow.
REQ-028 After Reset deasserts, the first Load is accepted at the first rising edge where Load=1.

Verification
REQ-029 Reset pulse low, then high with Load=0 for 5 cycles -> Ready=1, Sout_valid=0, Sout=0, Done=0 throughout.
REQ-030 MSB_FIRST=1, A=0xA5C3, Load one cycle -> Sout over the 16 Sout_valid cycles = 1010 0101 1100 0011; Done=1 in cycle k+17; Ready=1 in cycle k+18.
REQ-031 MSB_FIRST=0, A=0x0001 -> Sout=1 in the first valid cycle only, then 15 zeros.
REQ-032 Load A=0xFFFF, then assert Load with A=0x0000 in cycle k+5 and in cycle k+17 -> all 16 output bits=1; both later loads ignored.
REQ-033 Load A=0x1234, then Reset low in cycle k+8 -> outputs reach reset values without a clock edge; no Done pulse; the next Load with A=0x8001 transmits 0x8001 correctly.
REQ-034 Load held high with A=0xF0F0 -> back-to-back transfers with Done pulses 18 cycles apart and one Ready=1 cycle between transfers.
